snn_layer_sequencer: RTL and testbench

Programmable scheduler that drives the layer manager's execution-control port (execute_layer_id / execute_start / execute_done). It walks a host-loaded schedule table of layer IDs in order, once per timestep, for N timesteps. It reports progress, per-timestep completion, watchdog timeout and abort. It sits between the AXI-Lite control registers and the layer manager.

---
 rtl/snn_ctrl_pkg.sv | 21 ++
 rtl/snn_layer_sequencer_if.sv | 23 ++
 rtl/snn_seq_watchdog.sv | 41 ++++
 rtl/snn_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_snn_layer_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding, error codes and
// the reset value used for every schedule table entry.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StAdvance,
    StFinish
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CONFIG  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam logic [7:0] LAYER_ID_INVALID = 8'hFF;

endpackage

// File: rtl/snn_layer_sequencer_if.sv
// Execution-control port between the sequencer (master) and the layer manager (slave).
//   execute_layer_id : layer to run, held between issues
//   execute_start    : one-cycle start pulse
//   execute_done     : layer manager idle flag (high = idle)
interface snn_layer_sequencer_if;

  logic [7:0] execute_layer_id;
  logic       execute_start;
  logic       execute_done;

  modport master (
    output execute_layer_id,
    output execute_start,
    input  execute_done
  );

  modport slave (
    input  execute_layer_id,
    input  execute_start,
    output execute_done
  );

endinterface

// File: rtl/snn_seq_watchdog.sv
// Per-layer watchdog for the sequencer.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : clear the count (asserted when a layer is issued)
//   enable_i   : count this cycle (asserted while waiting on the layer manager)
//   limit_i    : number of waiting cycles allowed; 0 disables the watchdog
//   expired_o  : high during the limit-th waiting cycle
module snn_seq_watchdog #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturating count so a disabled watchdog never wraps during a long layer.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of waiting cycles already spent before this one.
  assign expired_o = enable_i && (limit_i != '0) && (cnt_q >= (limit_i - 1'b1));

endmodule

// File: rtl/snn_layer_sequencer.sv
// Walks a host-loaded table of layer IDs once per timestep for num_timesteps
// timesteps, handshaking each layer with the layer manager.
//   clk, reset          : clock, synchronous active-high reset
//   sched_wr_*          : table write port, honoured only while idle
//   num_layers          : entries per timestep (1..MAX_LAYERS)
//   num_timesteps       : timesteps per run (non-zero)
//   timeout_cycles      : per-layer watchdog limit, 0 disables
//   seq_start/seq_abort : run control
//   exec_if             : execution-control port to the layer manager
//   busy, timestep_done, seq_done, seq_error, error_code : status
//   current_index, current_timestep : progress
module snn_layer_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAYERS    = 16,
  parameter int unsigned IDX_WIDTH     = 4,
  parameter int unsigned TS_WIDTH      = 16,
  parameter int unsigned TIMEOUT_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sched_wr_en,
  input  logic [IDX_WIDTH-1:0]     sched_wr_addr,
  input  logic [7:0]               sched_wr_layer_id,
  input  logic [IDX_WIDTH:0]       num_layers,
  input  logic [TS_WIDTH-1:0]      num_timesteps,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                     seq_start,
  input  logic                     seq_abort,
  snn_layer_sequencer_if.master    exec_if,
  output logic                     busy,
  output logic                     timestep_done,
  output logic                     seq_done,
  output logic                     seq_error,
  output logic [1:0]               error_code,
  output logic [IDX_WIDTH-1:0]     current_index,
  output logic [TS_WIDTH-1:0]      current_timestep
);

  seq_state_e           state_q, state_d;
  logic [7:0]           sched_tbl_q [MAX_LAYERS];
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [IDX_WIDTH:0]   nl_q, nl_d;
  logic [TS_WIDTH-1:0]  nts_q, nts_d;
  logic [1:0]           err_q, err_d;
  logic [7:0]           layer_id_q, layer_id_d;
  logic                 exec_start;
  logic                 wd_expired;
  logic                 cfg_ok, last_layer, last_ts;

  assign cfg_ok     = (num_layers != '0) && (32'(num_layers) <= MAX_LAYERS)
                      && (num_timesteps != '0);
  assign last_layer = ({1'b0, idx_q} == (nl_q - 1'b1));
  assign last_ts    = (ts_q == (nts_q - 1'b1));

  snn_seq_watchdog #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .load_i    (state_q == StIssue),
    .enable_i  ((state_q == StWaitAck) || (state_q == StWaitDone)),
    .limit_i   (timeout_cycles),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ts_d          = ts_q;
    nl_d          = nl_q;
    nts_d         = nts_q;
    err_d         = err_q;
    layer_id_d    = layer_id_q;
    exec_start    = 1'b0;
    timestep_done = 1'b0;
    seq_done      = 1'b0;

    if ((state_q != StIdle) && seq_abort) begin
      state_d = StIdle;
      err_d   = ERR_ABORT;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_start) begin
            if (cfg_ok) begin
              nl_d    = num_layers;
              nts_d   = num_timesteps;
              idx_d   = '0;
              ts_d    = '0;
              err_d   = ERR_NONE;
              state_d = StIssue;
            end else begin
              err_d = ERR_CONFIG;
            end
          end
        end
        StIssue: begin
          exec_start = 1'b1;
          layer_id_d = sched_tbl_q[idx_q];
          state_d    = StWaitAck;
        end
        StWaitAck: begin
          if (wd_expired) begin
            err_d   = ERR_TIMEOUT;
            state_d = StIdle;
          end else if (!exec_if.execute_done) begin
            state_d = StWaitDone;
          end
        end
        StWaitDone: begin
          if (wd_expired) begin
            err_d   = ERR_TIMEOUT;
            state_d = StIdle;
          end else if (exec_if.execute_done) begin
            state_d = StAdvance;
          end
        end
        StAdvance: begin
          if (!last_layer) begin
            idx_d   = idx_q + 1'b1;
            state_d = StIssue;
          end else begin
            timestep_done = 1'b1;
            idx_d         = '0;
            if (last_ts) begin
              state_d = StFinish;
            end else begin
              ts_d    = ts_q + 1'b1;
              state_d = StIssue;
            end
          end
        end
        StFinish: begin
          seq_done = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ts_q       <= '0;
      nl_q       <= '0;
      nts_q      <= '0;
      err_q      <= ERR_NONE;
      layer_id_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ts_q       <= ts_d;
      nl_q       <= nl_d;
      nts_q      <= nts_d;
      err_q      <= err_d;
      layer_id_q <= layer_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        sched_tbl_q[i] <= LAYER_ID_INVALID;
      end
    end else if ((state_q == StIdle) && sched_wr_en) begin
      sched_tbl_q[sched_wr_addr] <= sched_wr_layer_id;
    end
  end

  // The table entry is shown combinationally during the issue cycle, then held.
  assign exec_if.execute_layer_id = (state_q == StIssue) ? sched_tbl_q[idx_q] : layer_id_q;
  assign exec_if.execute_start    = exec_start;

  assign busy             = (state_q == StIssue) || (state_q == StWaitAck) ||
                            (state_q == StWaitDone) || (state_q == StAdvance);
  assign error_code       = err_q;
  assign seq_error        = (err_q != ERR_NONE);
  assign current_index    = idx_q;
  assign current_timestep = ts_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
module tb_snn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_wr_en;
  logic [3:0]  sched_wr_addr;
  logic [7:0]  sched_wr_layer_id;
  logic [4:0]  num_layers;
  logic [15:0] num_timesteps;
  logic [19:0] timeout_cycles;
  logic        seq_start;
  logic        seq_abort;
  logic        busy;
  logic        timestep_done;
  logic        seq_done;
  logic        seq_error;
  logic [1:0]  error_code;
  logic [3:0]  current_index;
  logic [15:0] current_timestep;

  always #5 clk = ~clk;

  snn_layer_sequencer_if exec_if ();

  snn_layer_sequencer #(
    .MAX_LAYERS    (16),
    .IDX_WIDTH     (4),
    .TS_WIDTH      (16),
    .TIMEOUT_WIDTH (20)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .sched_wr_en       (sched_wr_en),
    .sched_wr_addr     (sched_wr_addr),
    .sched_wr_layer_id (sched_wr_layer_id),
    .num_layers        (num_layers),
    .num_timesteps     (num_timesteps),
    .timeout_cycles    (timeout_cycles),
    .seq_start         (seq_start),
    .seq_abort         (seq_abort),
    .exec_if           (exec_if),
    .busy              (busy),
    .timestep_done     (timestep_done),
    .seq_done          (seq_done),
    .seq_error         (seq_error),
    .error_code        (error_code),
    .current_index     (current_index),
    .current_timestep  (current_timestep)
  );

  typedef struct {
    logic [7:0] id;
    int         idx;
    int         ts;
  } issue_t;

  issue_t     exp_q[$];
  issue_t     e;
  logic [7:0] tbl_m [16];
  logic [7:0] obs_id[$];
  int         start_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         nstarts = 0;
  int         tsd_cnt = 0;
  int         sd_cnt = 0;
  int         rem = 0;
  bit         hang = 1'b0;
  int         drv_start_cyc, n0, idle_cyc;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Expected issue order: every table entry in order, once per timestep.
  task automatic expect_issues(input int nl, input int nts, input int cnt);
    int n = 0;
    exp_q.delete();
    for (int t = 0; t < nts; t++) begin
      for (int i = 0; i < nl; i++) begin
        if (n < cnt) begin
          exp_q.push_back('{id: tbl_m[i], idx: i, ts: t});
          n++;
        end
      end
    end
  endtask

  // Layer manager: goes busy after a start, idle again 4 cycles after it.
  initial begin
    exec_if.execute_done = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        exec_if.execute_done = 1'b1;
        rem = 0;
      end else if (exec_if.execute_start) begin
        exec_if.execute_done = 1'b0;
        rem = 4;
      end else begin
        if (rem > 0) rem--;
        if (rem == 0 && !hang) exec_if.execute_done = 1'b1;
      end
    end
  end

  // Compare process: every issued layer against the model order.
  always @(negedge clk) begin
    if (!reset) begin
      check("err_flag_consistent", {31'b0, seq_error}, {31'b0, error_code != 2'd0});
      if (exec_if.execute_start) begin
        nstarts++;
        obs_id.push_back(exec_if.execute_layer_id);
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_start", {31'b0, exec_if.execute_start}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("layer_id", {24'b0, exec_if.execute_layer_id}, {24'b0, e.id});
          check("issue_index", {28'b0, current_index}, e.idx);
          check("issue_timestep", {16'b0, current_timestep}, e.ts);
        end
      end
      if (timestep_done) tsd_cnt++;
      if (seq_done) sd_cnt++;
    end
  end

  task automatic write_entry(input int addr, input logic [7:0] id, input bit model);
    sched_wr_en = 1'b1;
    sched_wr_addr = addr[3:0];
    sched_wr_layer_id = id;
    if (model) tbl_m[addr] = id;
    @(posedge clk); #1;
    sched_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    seq_start = 1'b1;
    drv_start_cyc = cyc;
    @(posedge clk); #1;
    seq_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < lim);
    if (busy) check("wait_idle_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (nstarts < n && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (nstarts < n) check("wait_start_bound", nstarts, n);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_start"}, {31'b0, exec_if.execute_start}, 32'd0);
    check({tag, "_layer_id"}, {24'b0, exec_if.execute_layer_id}, 32'd0);
    check({tag, "_ts_done"}, {31'b0, timestep_done}, 32'd0);
    check({tag, "_seq_done"}, {31'b0, seq_done}, 32'd0);
    check({tag, "_seq_error"}, {31'b0, seq_error}, 32'd0);
    check({tag, "_error_code"}, {30'b0, error_code}, 32'd0);
    check({tag, "_index"}, {28'b0, current_index}, 32'd0);
    check({tag, "_timestep"}, {16'b0, current_timestep}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] want1 [6];
    want1 = '{8'd3, 8'd5, 8'd7, 8'd3, 8'd5, 8'd7};
    reset = 1'b1;
    sched_wr_en = 1'b0;
    sched_wr_addr = '0;
    sched_wr_layer_id = '0;
    num_layers = '0;
    num_timesteps = '0;
    timeout_cycles = '0;
    seq_start = 1'b0;
    seq_abort = 1'b0;
    for (int i = 0; i < 16; i++) tbl_m[i] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("reset");

    // Normal run: table {3,5,7}, 3 layers x 2 timesteps.
    write_entry(0, 8'd3, 1'b1);
    write_entry(1, 8'd5, 1'b1);
    write_entry(2, 8'd7, 1'b1);
    num_layers = 5'd3;
    num_timesteps = 16'd2;
    timeout_cycles = '0;
    obs_id.delete();
    start_cyc.delete();
    tsd_cnt = 0;
    sd_cnt = 0;
    expect_issues(3, 2, 6);
    pulse_start();
    wait_idle(200);
    @(posedge clk); #1;
    check("run_leftover", exp_q.size(), 0);
    check("run_issue_count", obs_id.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_id.size()) check("run_id_literal", {24'b0, obs_id[i]}, {24'b0, want1[i]});
    end
    check("run_ts_done_pulses", tsd_cnt, 2);
    check("run_seq_done_pulses", sd_cnt, 1);
    check("run_error_code", {30'b0, error_code}, 32'd0);
    check("run_busy_after", {31'b0, busy}, 32'd0);
    check("run_final_index", {28'b0, current_index}, 32'd0);
    check("run_final_timestep", {16'b0, current_timestep}, 32'd1);
    if (start_cyc.size() >= 2) begin
      check("start_latency", start_cyc[0] - drv_start_cyc, 1);
      check("done_to_start_gap", start_cyc[1] - start_cyc[0], 6);
    end

    // Bad configurations.
    n0 = nstarts;
    exp_q.delete();
    num_layers = 5'd0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("cfg0_busy", {31'b0, busy}, 32'd0);
    check("cfg0_error_code", {30'b0, error_code}, 32'd1);
    check("cfg0_seq_error", {31'b0, seq_error}, 32'd1);
    num_layers = 5'd17;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("cfg17_busy", {31'b0, busy}, 32'd0);
    check("cfg17_error_code", {30'b0, error_code}, 32'd1);
    num_layers = 5'd3;
    num_timesteps = 16'd0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("cfg_ts0_busy", {31'b0, busy}, 32'd0);
    check("cfg_ts0_error_code", {30'b0, error_code}, 32'd1);
    check("cfg_no_starts", nstarts - n0, 0);

    // Watchdog: layer manager never returns to idle.
    hang = 1'b1;
    num_layers = 5'd3;
    num_timesteps = 16'd1;
    timeout_cycles = 20'd10;
    start_cyc.delete();
    expect_issues(3, 1, 1);
    n0 = nstarts;
    pulse_start();
    check("to_error_cleared", {30'b0, error_code}, 32'd0);
    check("to_busy", {31'b0, busy}, 32'd1);
    wait_idle(100);
    idle_cyc = cyc;
    if (start_cyc.size() >= 1) check("to_latency", idle_cyc - start_cyc[0], 11);
    repeat (20) @(posedge clk);
    #1;
    check("to_error_code", {30'b0, error_code}, 32'd2);
    check("to_seq_error", {31'b0, seq_error}, 32'd1);
    check("to_busy_after", {31'b0, busy}, 32'd0);
    check("to_issue_count", nstarts - n0, 1);
    hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Abort during WAIT_DONE of index 1, timestep 0.
    timeout_cycles = '0;
    num_layers = 5'd3;
    num_timesteps = 16'd2;
    expect_issues(3, 2, 2);
    tsd_cnt = 0;
    n0 = nstarts;
    pulse_start();
    wait_starts(n0 + 2, 100);
    @(posedge clk); #1;
    seq_abort = 1'b1;
    @(posedge clk); #1;
    seq_abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_error_code", {30'b0, error_code}, 32'd3);
    check("abort_seq_error", {31'b0, seq_error}, 32'd1);
    check("abort_index", {28'b0, current_index}, 32'd1);
    check("abort_timestep", {16'b0, current_timestep}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_issue_count", nstarts - n0, 2);
    check("abort_ts_done", tsd_cnt, 0);

    // Table write while busy is dropped.
    num_layers = 5'd1;
    num_timesteps = 16'd1;
    expect_issues(1, 1, 1);
    n0 = nstarts;
    pulse_start();
    wait_starts(n0 + 1, 100);
    write_entry(0, 8'd9, 1'b0);
    wait_idle(100);
    @(posedge clk); #1;
    expect_issues(1, 1, 1);
    pulse_start();
    wait_idle(100);
    @(posedge clk); #1;
    check("busy_write_ignored", {24'b0, obs_id[obs_id.size() - 1]}, 32'd3);

    // Write and start in the same cycle: the run sees the new entry.
    sched_wr_en = 1'b1;
    sched_wr_addr = 4'd0;
    sched_wr_layer_id = 8'd9;
    tbl_m[0] = 8'd9;
    expect_issues(1, 1, 1);
    pulse_start();
    sched_wr_en = 1'b0;
    wait_idle(100);
    @(posedge clk); #1;
    check("idle_write_used", {24'b0, obs_id[obs_id.size() - 1]}, 32'd9);
    check("idle_write_error", {30'b0, error_code}, 32'd0);

    // Abort in IDLE is ignored.
    seq_abort = 1'b1;
    @(posedge clk); #1;
    seq_abort = 1'b0;
    @(posedge clk); #1;
    check("idle_abort_error", {30'b0, error_code}, 32'd0);
    check("idle_abort_busy", {31'b0, busy}, 32'd0);

    // Reset mid-run clears everything, including the table.
    num_layers = 5'd3;
    num_timesteps = 16'd2;
    expect_issues(3, 2, 6);
    n0 = nstarts;
    pulse_start();
    wait_starts(n0 + 1, 100);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) tbl_m[i] = 8'hFF;
    @(posedge clk); #1;
    num_layers = 5'd1;
    num_timesteps = 16'd1;
    expect_issues(1, 1, 1);
    pulse_start();
    wait_idle(100);
    @(posedge clk); #1;
    check("reset_table_id", {24'b0, obs_id[obs_id.size() - 1]}, 32'hFF);
    check("reset_run_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
